// File: rtl/decode_issue_stage.sv
// Decode/register-read stage: classifies ARM DP, LDR/STR and B/BL, gates on the condition field, reads two sources.
// Latency: one cycle from accept to out_valid; out_undef pulses the cycle after accept.
// Backpressure: in_ready drops on flush, a held output, source/flag hazards or a saturated scoreboard counter.
module decode_issue_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int REG_AW = 4,
    parameter int SB_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] pc,
    input  logic [3:0]        flags,
    input  logic              flags_wb,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              flush,
    output logic [REG_AW-1:0] rf_addr1,
    output logic [REG_AW-1:0] rf_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_kind,
    output logic [3:0]        out_op,
    output logic              out_s,
    output logic              out_link,
    output logic              out_imm,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [11:0]       out_operand,
    output logic [23:0]       out_boff,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_we,
    output logic              out_undef
);

    localparam logic [SB_W-1:0]   SB_MAX = '1;
    localparam logic [REG_AW-1:0] LR     = REG_AW'(14);

    logic [SB_W-1:0]   sb [NREG];
    logic [SB_W-1:0]   fpend;
    logic              out_fw;

    logic [3:0]        cond, op;
    logic [REG_AW-1:0] rn, rd, rm;
    logic              is_br, is_mem, is_dp, ibit, lbit;
    logic              undef, movmvn, test_op;
    logic              use1, use2, we, fw, link;
    logic [REG_AW-1:0] addr1, addr2, dst;
    logic              cond_base, cond_pass, exec;
    logic              hazard, full, accept, issue, squash;

    assign cond    = inst[31:28];
    assign op      = inst[24:21];
    assign rn      = REG_AW'(inst[19:16]);
    assign rd      = REG_AW'(inst[15:12]);
    assign rm      = REG_AW'(inst[3:0]);
    assign ibit    = inst[25];
    assign lbit    = inst[20];

    assign is_br   = (inst[27:25] == 3'b101);
    assign is_mem  = (inst[27:26] == 2'b01);
    assign is_dp   = (inst[27:26] == 2'b00);
    // Register-offset LDR/STR is not supported and falls into the undefined class.
    assign undef   = !(is_br || is_dp || (is_mem && !ibit));
    assign movmvn  = (op[3:2] == 2'b11) && op[0];
    assign test_op = (op[3:2] == 2'b10);

    assign use1    = (is_dp && !(movmvn && ibit)) || (is_mem && !ibit);
    assign use2    = (is_dp && !ibit && !movmvn) || (is_mem && !ibit && !lbit);
    assign addr1   = !use1 ? '0 : (is_dp && movmvn) ? rm : rn;
    assign addr2   = !use2 ? '0 : is_dp ? rm : rd;
    assign link    = is_br && inst[24];
    assign we      = (is_dp && !test_op) || (is_mem && !ibit && lbit) || link;
    assign fw      = is_dp && (lbit || test_op);
    assign dst     = is_br ? LR : rd;

    assign rf_addr1 = addr1;
    assign rf_addr2 = addr2;

    // Codes pair up as (test, inverted test) on cond[0]; 111x is AL/NV.
    always_comb begin
        cond_base = 1'b1;
        unique case (cond[3:1])
            3'd0: cond_base = flags[2];
            3'd1: cond_base = flags[1];
            3'd2: cond_base = flags[3];
            3'd3: cond_base = flags[0];
            3'd4: cond_base = flags[1] && !flags[2];
            3'd5: cond_base = (flags[3] == flags[0]);
            3'd6: cond_base = !flags[2] && (flags[3] == flags[0]);
            3'd7: cond_base = 1'b1;
        endcase
        cond_pass = (cond[3:1] == 3'b111) ? !cond[0] : (cond_base ^ cond[0]);
    end

    assign exec     = cond_pass && !undef;
    assign hazard   = (use1 && sb[addr1] != '0) || (use2 && sb[addr2] != '0) ||
                      (cond != 4'hE && fpend != '0);
    assign full     = exec && ((we && sb[dst] == SB_MAX) || (fw && fpend == SB_MAX));
    assign in_ready = !flush && !(out_valid && !out_ready) && !hazard && !full;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && exec;
    assign squash   = flush && out_valid;

    // Increment first, then apply each decrement saturating at zero.
    function automatic logic [SB_W-1:0] cnt_next(input logic [SB_W-1:0] c, input logic inc,
                                                 input logic d1, input logic d2);
        logic [SB_W-1:0] t;
        t = c + SB_W'(inc);
        if (d1 && t != '0) t = t - SB_W'(1);
        if (d2 && t != '0) t = t - SB_W'(1);
        return t;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) sb[r] <= '0;
            fpend       <= '0;
            out_valid   <= 1'b0;
            out_kind    <= '0;
            out_op      <= '0;
            out_s       <= 1'b0;
            out_link    <= 1'b0;
            out_imm     <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_operand <= '0;
            out_boff    <= '0;
            out_dst     <= '0;
            out_we      <= 1'b0;
            out_fw      <= 1'b0;
            out_undef   <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                sb[r] <= cnt_next(sb[r],
                                  issue && we && dst == REG_AW'(r),
                                  wb_valid && wb_addr == REG_AW'(r),
                                  squash && out_we && out_dst == REG_AW'(r));
            end
            fpend     <= cnt_next(fpend, issue && fw, flags_wb, squash && out_fw);
            out_undef <= accept && undef;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (issue) begin
                out_valid   <= 1'b1;
                out_kind    <= is_br ? 2'd3 : is_dp ? 2'd0 : lbit ? 2'd1 : 2'd2;
                out_op      <= op;
                out_s       <= is_dp && lbit;
                out_link    <= link;
                out_imm     <= ibit && !is_br;
                out_a       <= link ? pc : rf_data1;
                out_b       <= rf_data2;
                out_operand <= inst[11:0];
                out_boff    <= inst[23:0];
                out_dst     <= dst;
                out_we      <= we;
                out_fw      <= fw;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised decode/register-read stage for the pipelined ARM core. It sits between fetch and execute. It decodes data-processing, LDR/STR and B/BL instructions, evaluates the condition field against the architectural flags, and reads up to two source registers. It tracks in-flight register and flag writers with a counting scoreboard, stalling on hazards, and issues through a one-entry valid/ready output register with flush support.

## Interface
- DATA_W, 32, register/PC data width
- NREG, 16, architectural register count
- REG_AW, 4, register address width (clog2(NREG))
- SB_W, 2, scoreboard counter width per register (max in-flight writers = 2^SB_W-1)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents inst/pc
- in_ready  out  1  stage accepts this cycle
- inst  in  32  ARM instruction word
- pc  in  DATA_W  address of inst
- flags  in  4  NZCV, architecturally current
- flags_wb  in  1  pulse: one flag-setting instruction retired
- wb_valid  in  1  pulse: one register write retired
- wb_addr  in  REG_AW  register retired by wb_valid
- flush  in  1  squash output entry and block accept this cycle
- rf_addr1, rf_addr2  out  REG_AW  combinational register-file read addresses
- rf_data1, rf_data2  in  DATA_W  combinational read data
- out_valid  out  1  issued instruction valid
- out_ready  in  1  execute accepts
- out_kind  out  2  0 DP, 1 LDR, 2 STR, 3 branch
- out_op  out  4  DP opcode inst[24:21]
- out_s, out_link, out_imm  out  1  flag-set, BL, immediate operand (I bit)
- out_a, out_b  out  DATA_W  operand values (rf_data1 / rf_data2, or pc for BL)
- out_operand  out  12  inst[11:0]
- out_boff  out  24  branch offset inst[23:0]
- out_dst  out  REG_AW  destination register
- out_we  out  1  instruction writes out_dst
- out_undef  out  1  one-cycle pulse: unsupported encoding dropped

## Operation
Classes:
- Branch: inst[27:25]=101. BL writes R14, out_a=pc.
- LDR/STR: inst[27:26]=01.
- DP: inst[27:26]=00.
- Anything else, or LDR/STR with I=1 (register offset), is undefined: accepted, dropped, out_undef pulses.

Sources:
- DP: port1=rn unless MOV/MVN. Port2=rm when I=0. For MOV/MVN with I=0, rm goes on port1.
- LDR: port1=rn.
- STR: port1=rn, port2=rd.
- Unused ports: address 0, not hazard-checked.

Destination and flags:
- DP writes rd unless op=10xx (TST/TEQ/CMP/CMN).
- LDR writes rd.
- BL writes R14.
- Flag writer: DP with S=1 or op=10xx.

Condition codes:
- Standard 14 codes plus AL (1110).
- 1111 is never-execute.
- Condition-false instructions are accepted and dropped: no output, no scoreboard change.

Scoreboard:
- sb[r] is an SB_W-bit counter per register; fpend is an SB_W-bit counter for flag writers.
- Issue increments sb[dst] if out_we, and fpend if flag writer.
- wb_valid decrements sb[wb_addr]; flags_wb decrements fpend.
- Simultaneous increment and decrement on the same counter leaves it unchanged.
- Decrement at 0 is ignored (saturate).

Stall: in_ready=0 when any of the following holds:
- flush=1
- out_valid && !out_ready
- a used source has sb≠0
- cond≠AL and fpend≠0
- the destination or flag counter to be incremented is at max

Accept/issue:
- Accept = in_valid && in_ready.
- A true-condition accept loads the output register next edge.
- An out_valid entry is held stable until out_ready.

Flush:
- Clears out_valid.
- If the squashed entry had out_we, decrements sb[out_dst].
- If the entry was a flag writer, decrements fpend.
- Retire decrements in the same cycle also apply, so a counter can drop by 2.

Reset: all counters 0; out_valid, out_undef and all out_* fields 0.

## Timing
- Latency: accept at edge N → out_valid from edge N+1.
- Throughput: 1/cycle with out_ready held high and no hazards.
- in_ready and rf_addr* are combinational from inst, counters, out_valid, out_ready and flush.
- A wb_valid retiring a source register unblocks that source on the following cycle (registered counter). The register file does not bypass.
- out_undef is registered: it pulses the cycle after accept.
- rst_n assertion mid-stall clears everything asynchronously. in_ready then re-evaluates from a clean scoreboard.

## Test plan
- ADD R1,R2,R3 (0xE0821003), sb all 0, rf_data1=5, rf_data2=7 → next cycle out_valid=1, out_kind=0, out_op=0100, out_a=5, out_b=7, out_dst=1, out_we=1; sb[1]=1.
- Back-to-back ADD R1 then SUB R4,R1,#1 → second stalled (in_ready=0) until wb_valid addr 1. Accepted cycle after the counter reaches 0.
- CMP R0,#0 issued, then BEQ with flags Z=1 → BEQ stalls while fpend=1. After flags_wb it issues with out_kind=3. With Z=0 it is dropped and no output appears.
- BL, pc=0x100 → out_link=1, out_a=0x100, out_dst=14; sb[14]=1.
- out_ready=0 holding ADD R1; flush=1 → out_valid=0 next cycle, sb[1] returns to 0, in_ready=0 during the flush cycle.
- STR with I=1, then 0xEC000000 → out_undef pulses once per instruction, out_valid stays 0, counters unchanged. Assert rst_n=0 mid-sequence → all outputs 0 immediately.
